forwarding_hazard_unit: RTL and testbench
=========================================

# forwarding_hazard_unit

Generates the select codes for the two 32-bit 3-to-1 forwarding multiplexers at the ALU inputs in the EX stage, plus the load-use stall request for the ID stage. It tracks its own three-entry destination pipeline (EX, MEM, WB), advanced one entry per clock as instructions leave ID. Its registered select outputs drive the forwarding muxes directly for the whole EX cycle. Its stall output freezes the PC and the IF/ID register.

## Interface
Parameters:
- REG_W, 5, register-specifier width (32 architectural registers; register 0 is hard-wired zero)

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- IdValid  in  1  ID stage holds a real instruction this cycle
- IdRs  in  REG_W  first source register of the ID instruction
- IdRt  in  REG_W  second source register of the ID instruction
- IdUsesRt  in  1  ID instruction actually reads Rt (R-type, store, branch)
- IdDst  in  REG_W  destination register chosen for the ID instruction (after RegDst)
- IdRegWrite  in  1  ID instruction writes the register file
- IdMemRead  in  1  ID instruction is a load
- Flush  in  1  taken branch/jump; ID instruction must not enter EX
- Stall  out  1  combinational load-use hazard request; high means hold PC and IF/ID
- FwdA  out  2  ALU operand A select: 0 register file, 1 EX/MEM result, 2 MEM/WB result
- FwdB  out  2  ALU operand B select, same encoding
- ExBubble  out  1  EX entry is a bubble (ID/EX control must be zeroed)

## Operation
- Internal entries: EX {valid, rs, rt, usesRt, dst, regWrite, memRead}; MEM {valid, dst, regWrite}; WB {valid, dst, regWrite}.
- A producer P matches source register s iff P.valid & P.regWrite & P.dst != 0 & P.dst == s.
- Stall = IdValid & EX.valid & EX.memRead & (EX matches IdRs | (IdUsesRt & EX matches IdRt)). Stall is purely combinational from state and ID inputs and is forced low during Reset.
- Advance: WB <= MEM, MEM <= EX (memRead dropped), every clock.
- EX load: if IdValid & !Stall & !Flush, EX <= ID fields; otherwise EX <= bubble (valid = 0).
- Select computation for the instruction entering EX, against the new MEM (old EX) and new WB (old MEM):
  - Operand A: 1 if new MEM matches rs.
  - Otherwise 2 if new WB matches rs.
  - Otherwise 0.
- Operand B: same rule on rt, and 0 whenever usesRt = 0.
- MEM has priority over WB; it holds the most recent producer.
- A load in new MEM never produces select 1. Stall guarantees the consumer arrives one cycle later, when the load sits in WB and gives select 2.
- Bubble entering EX: FwdA = FwdB = 0, ExBubble = 1.
- Flush together with Stall: the bubble is inserted once. Stall still reports the hazard; external flush logic has priority on IF/ID.
- The register file writes in the first half cycle and reads in the second half, so no WB-to-ID forwarding is generated here.

## Timing
- Reset (sampled on rising edge): all entry valids become 0, FwdA = FwdB = 0, ExBubble = 1, Stall = 0. Takes effect at that edge even mid-stall. The ID instruction present during reset is discarded.
- FwdA/FwdB/ExBubble are registered. They change only on a clock edge and stay stable for the full EX cycle of the instruction they belong to.
- Latency: a select is computed at the edge the instruction enters EX and is valid from that edge until the next.
- Load-use costs exactly one bubble: Stall is high one cycle, then the consumer enters EX with select 2.
- Back-to-back stalls cannot occur for a single load, since the load leaves EX after one cycle.

## Test plan
- Reset: hold Reset 2 cycles with IdValid = 1 and a load in flight -> Stall = 0, FwdA = FwdB = 0, ExBubble = 1 at the first edge after Reset. The next instruction enters with selects 0.
- EX/MEM forward: add $8 then add $9,$8,$8 consecutively -> second instruction in EX has FwdA = 1, FwdB = 1, Stall never high.
- MEM/WB forward plus priority:
  - add $8; nop; sub rs = $8 -> FwdA = 2.
  - add $8; add $8; sub rs = $8 -> FwdA = 1.
- Load-use: lw $8 then add $9,$8,$0 (IdUsesRt = 1) -> Stall = 1 for exactly one cycle, ExBubble = 1 the next cycle, then the add enters EX with FwdA = 2, FwdB = 0.
- Zero register and unused Rt:
  - add $0 then add rs = $0 -> FwdA = 0.
  - lw $8 then addi rs = $2, rt = $8, IdUsesRt = 0 -> Stall = 0, FwdB = 0.
- Flush: Flush = 1 with a valid add $8 in ID -> ExBubble = 1, FwdA = FwdB = 0. An add reading $8 two cycles later gets select 0.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// EX-stage forwarding select generator and load-use stall detector.
// Tracks the destination of the instructions in EX and MEM; selects are registered as an instruction enters EX.
module forwarding_hazard_unit #(
    parameter int unsigned REG_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IdValid,
    input  logic [REG_W-1:0] IdRs,
    input  logic [REG_W-1:0] IdRt,
    input  logic             IdUsesRt,
    input  logic [REG_W-1:0] IdDst,
    input  logic             IdRegWrite,
    input  logic             IdMemRead,
    input  logic             Flush,
    output logic             Stall,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             ExBubble
);

    // The WB entry is never consulted: selects look at the entries becoming MEM and WB,
    // which are the current EX and MEM, so only those two are held.
    logic             ex_valid_q, ex_reg_write_q, ex_mem_read_q;
    logic [REG_W-1:0] ex_dst_q;
    logic             mem_valid_q, mem_reg_write_q;
    logic [REG_W-1:0] mem_dst_q;
    logic [1:0]       fwd_a_q, fwd_b_q;
    logic             ex_bubble_q;

    logic             ex_valid_d, ex_reg_write_d, ex_mem_read_d;
    logic [REG_W-1:0] ex_dst_d;
    logic [1:0]       fwd_a_d, fwd_b_d;
    logic             ex_bubble_d;

    logic ex_prod, mem_prod;
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_ex;

    always_comb begin
        ex_prod    = ex_valid_q & ex_reg_write_q & (ex_dst_q != '0);
        mem_prod   = mem_valid_q & mem_reg_write_q & (mem_dst_q != '0);
        ex_hit_rs  = ex_prod & (ex_dst_q == IdRs);
        ex_hit_rt  = ex_prod & (ex_dst_q == IdRt);
        mem_hit_rs = mem_prod & (mem_dst_q == IdRs);
        mem_hit_rt = mem_prod & (mem_dst_q == IdRt);

        Stall   = !Reset & IdValid & ex_mem_read_q & (ex_hit_rs | (IdUsesRt & ex_hit_rt));
        load_ex = IdValid & !Stall & !Flush;
    end

    always_comb begin
        ex_valid_d     = load_ex;
        ex_dst_d       = IdDst;
        ex_reg_write_d = IdRegWrite;
        ex_mem_read_d  = IdMemRead;
        ex_bubble_d    = !load_ex;

        fwd_a_d = 2'd0;
        if (load_ex) begin
            if (ex_hit_rs)       fwd_a_d = 2'd1;
            else if (mem_hit_rs) fwd_a_d = 2'd2;
        end

        fwd_b_d = 2'd0;
        if (load_ex && IdUsesRt) begin
            if (ex_hit_rt)       fwd_b_d = 2'd1;
            else if (mem_hit_rt) fwd_b_d = 2'd2;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_valid_q      <= 1'b0;
            ex_dst_q        <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_dst_q       <= '0;
            mem_reg_write_q <= 1'b0;
            fwd_a_q         <= 2'd0;
            fwd_b_q         <= 2'd0;
            ex_bubble_q     <= 1'b1;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_dst_q        <= ex_dst_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_valid_q     <= ex_valid_q;
            mem_dst_q       <= ex_dst_q;
            mem_reg_write_q <= ex_reg_write_q;
            fwd_a_q         <= fwd_a_d;
            fwd_b_q         <= fwd_b_d;
            ex_bubble_q     <= ex_bubble_d;
        end
    end

    assign FwdA     = fwd_a_q;
    assign FwdB     = fwd_b_q;
    assign ExBubble = ex_bubble_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench: directed test-plan steps followed by random instruction streams,
// compared against a history-of-issued-instructions reference model.
module tb_forwarding_hazard_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       IdValid = 1'b0;
    logic [4:0] IdRs = '0, IdRt = '0, IdDst = '0;
    logic       IdUsesRt = 1'b0, IdRegWrite = 1'b0, IdMemRead = 1'b0, Flush = 1'b0;
    logic       Stall, ExBubble;
    logic [1:0] FwdA, FwdB;

    forwarding_hazard_unit #(.REG_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
        .IdUsesRt(IdUsesRt), .IdDst(IdDst), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .Flush(Flush), .Stall(Stall), .FwdA(FwdA), .FwdB(FwdB), .ExBubble(ExBubble)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
    } ent_t;

    // hist[0] = instruction currently in EX, hist[1] = instruction currently in MEM
    ent_t hist [2];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic last_stall = 1'b0;

    function automatic logic produces(ent_t p, logic [4:0] s);
        return p.v && p.rw && p.dst != 5'd0 && p.dst == s;
    endfunction

    // Most recent matching producer wins: 1 = EX/MEM, 2 = MEM/WB.
    function automatic logic [1:0] pick(logic [4:0] s);
        for (int k = 0; k < 2; k++)
            if (produces(hist[k], s)) return 2'(k + 1);
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic fl, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ur, input logic [4:0] dst,
                         input logic rw, input logic mr);
        logic       exp_stall, enter;
        logic [1:0] exp_a, exp_b;
        ent_t       incoming;
        Reset = rst; Flush = fl; IdValid = v; IdRs = rs; IdRt = rt; IdUsesRt = ur;
        IdDst = dst; IdRegWrite = rw; IdMemRead = mr;
        #2;
        exp_stall = !rst && v && hist[0].mr && (produces(hist[0], rs) || (ur && produces(hist[0], rt)));
        chk("stall", {1'b0, Stall}, {1'b0, exp_stall});
        last_stall = exp_stall;
        enter = !rst && v && !exp_stall && !fl;
        exp_a = enter ? pick(rs) : 2'd0;
        exp_b = (enter && ur) ? pick(rt) : 2'd0;
        @(posedge Clk);
        if (rst) begin
            hist[0] = '0;
            hist[1] = '0;
        end else begin
            incoming = '{v: enter, dst: dst, rw: rw, mr: mr};
            hist[1] = hist[0];
            hist[0] = incoming;
        end
        #1;
        chk("fwdA", FwdA, exp_a);
        chk("fwdB", FwdB, exp_b);
        chk("bubble", {1'b0, ExBubble}, {1'b0, !enter});
    endtask

    logic       r_v, r_ur, r_rw, r_mr, r_fl, r_rst;
    logic [4:0] r_rs, r_rt, r_dst;

    initial begin
        hist[0] = '0;
        hist[1] = '0;
        // reset with a load in flight and a dependent instruction in ID
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 5'd1, 5'd0, 0, 5'd8, 1, 1);
        cycle(1, 0, 1, 5'd8, 5'd8, 1, 5'd9, 1, 0);
        cycle(1, 0, 1, 5'd8, 5'd8, 1, 5'd9, 1, 0);
        chk("reset_bubble", {1'b0, ExBubble}, 2'd1);
        cycle(0, 0, 1, 5'd8, 5'd8, 1, 5'd9, 1, 0);
        chk("post_reset_fwdA", FwdA, 2'd0);

        // EX/MEM forward on both operands
        cycle(0, 0, 1, 5'd1, 5'd2, 1, 5'd8, 1, 0);
        cycle(0, 0, 1, 5'd8, 5'd8, 1, 5'd9, 1, 0);
        chk("exmem_A", FwdA, 2'd1);
        chk("exmem_B", FwdB, 2'd1);

        // MEM/WB forward, then MEM priority
        cycle(0, 0, 1, 5'd1, 5'd2, 1, 5'd8, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 5'd8, 5'd3, 1, 5'd10, 1, 0);
        chk("memwb_A", FwdA, 2'd2);
        cycle(0, 0, 1, 5'd1, 5'd2, 1, 5'd8, 1, 0);
        cycle(0, 0, 1, 5'd3, 5'd4, 1, 5'd8, 1, 0);
        cycle(0, 0, 1, 5'd8, 5'd3, 1, 5'd10, 1, 0);
        chk("priority_A", FwdA, 2'd1);

        // load-use: one stall, one bubble, then select 2
        cycle(0, 0, 1, 5'd1, 5'd0, 0, 5'd8, 1, 1);
        cycle(0, 0, 1, 5'd8, 5'd0, 1, 5'd9, 1, 0);
        chk("lu_stall", {1'b0, last_stall}, 2'd1);
        chk("lu_bubble", {1'b0, ExBubble}, 2'd1);
        cycle(0, 0, 1, 5'd8, 5'd0, 1, 5'd9, 1, 0);
        chk("lu_A", FwdA, 2'd2);
        chk("lu_B", FwdB, 2'd0);

        // zero register and unused Rt
        cycle(0, 0, 1, 5'd1, 5'd2, 1, 5'd0, 1, 0);
        cycle(0, 0, 1, 5'd0, 5'd2, 1, 5'd9, 1, 0);
        chk("zero_A", FwdA, 2'd0);
        cycle(0, 0, 1, 5'd1, 5'd0, 0, 5'd8, 1, 1);
        cycle(0, 0, 1, 5'd2, 5'd8, 0, 5'd9, 1, 0);
        chk("unused_rt_B", FwdB, 2'd0);

        // flush, including flush during a stall
        cycle(0, 1, 1, 5'd1, 5'd2, 1, 5'd8, 1, 0);
        chk("flush_bubble", {1'b0, ExBubble}, 2'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 5'd8, 5'd8, 1, 5'd9, 1, 0);
        chk("flush_A", FwdA, 2'd0);
        cycle(0, 0, 1, 5'd1, 5'd0, 0, 5'd8, 1, 1);
        cycle(0, 1, 1, 5'd8, 5'd0, 0, 5'd9, 1, 0);
        cycle(0, 0, 1, 5'd8, 5'd0, 0, 5'd9, 1, 0);

        // random streams on a small register set to force frequent hazards
        r_v = 0; r_ur = 0; r_rw = 0; r_mr = 0; r_fl = 0; r_rst = 0;
        r_rs = '0; r_rt = '0; r_dst = '0;
        for (int i = 0; i < 600; i++) begin
            if (!(last_stall && !r_fl && !r_rst)) begin
                r_v   = ($urandom_range(0, 7) != 0);
                r_rs  = 5'($urandom_range(0, 3));
                r_rt  = 5'($urandom_range(0, 3));
                r_dst = 5'($urandom_range(0, 3));
                r_ur  = ($urandom_range(0, 1) != 0);
                r_rw  = ($urandom_range(0, 3) != 0);
                r_mr  = ($urandom_range(0, 2) == 0);
            end
            r_fl  = ($urandom_range(0, 7) == 0);
            r_rst = ($urandom_range(0, 63) == 0);
            cycle(r_rst, r_fl, r_v, r_rs, r_rt, r_ur, r_dst, r_rw, r_mr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
